ext_arbiter: RTL and testbench
==============================

EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of read transactions that may be outstanding at once (power of two, 2..8).
REQ-002 SHALL have parameter STARVE, default 8: number of lost ic cycles before ic gets priority.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst (active-high, synchronous) is its reset.
REQ-004 SHALL have ports, one per line:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- dcaddr in 32: dcache request address.
- dcsz in 5: dcache request size code.
- dcreq in 1: dcache request valid.
- dcwr in 1: dcache request is a write.
- dcwdata in 64: dcache write beat data.
- dcrdy out 1: dcache beat accepted this cycle.
- icaddr in 32: icache request address (reads only).
- icsz in 5: icache request size code.
- icreq in 1: icache request valid.
- icrdy out 1: icache beat accepted this cycle.
- extaddr out 32: bus request address.
- extsz out 5: bus request size code.
- extreq out 1: bus request valid.
- extwr out 1: bus request is a write.
- extwdata out 64: bus write data.
- extsrc out 1: bus request source, 1 = dc, 0 = ic.
- extrdy in 1: bus accepts the current beat.
- busreply in 1: read reply beat valid.
- busrdata in 64: read reply data.
- buserror in 1: reply bus error.
- extreply out 1: reply beat to the caches.
- extreplyto out 1: reply destination, 1 = dc, 0 = ic.
- extrdata out 64: reply data to the caches.
- exterror out 1: reply error to the caches.
- outstanding out 4: number of read transactions in flight.
- protoerr out 1: sticky flag, reply received with nothing outstanding.

Function
REQ-005 SHALL compute the beats for size code sz as: sz<=7 gives 1 beat; 15 gives 2; 31 gives 4; any other code gives 1 beat.
REQ-006 SHALL have states IDLE and WLOCK; a beat is accepted when extreq && extrdy.
REQ-007 In IDLE, SHALL treat dc as eligible when dcreq && (dcwr || !full), and ic as eligible when icreq && !full; full means outstanding==DEPTH, taken from the registered count.
REQ-008 In IDLE, dc SHALL win whenever it is eligible, unless the ic priority condition of REQ-014 holds and ic is eligible.
REQ-009 SHALL drive the winner's addr, sz, wr and wdata onto ext* combinationally, set extreq=1 and extsrc to the winner, set the winner's rdy=extrdy, and set the loser's rdy=0; with no winner, extreq=0 and both rdy=0.
REQ-010 SHALL push {src, beats-1} into the outstanding FIFO when a read is accepted.
REQ-011 SHALL go IDLE->WLOCK when a dc write with dcsz==15 is accepted.
REQ-012 In WLOCK, SHALL grant dc only (extsrc=1, extwr=1, extwdata=dcwdata), ignore extaddr and extsz, never grant ic, and return to IDLE on acceptance.
REQ-013 SHALL produce extreply=busreply, extrdata=busrdata, exterror=buserror and extreplyto=FIFO head src, all combinationally.
- Each reply beat decrements the head's beat counter.
- On the last beat the head is popped.
- A push and a pop in the same cycle SHALL both take effect, with the count unchanged.
REQ-014 SHALL keep a starvation counter:
- Increments, saturating at STARVE, each cycle icreq=1 and icrdy=0.
- Clears when an ic beat is accepted.
- When it equals STARVE, ic has priority in IDLE.
REQ-015 When busreply=1 and the FIFO is empty, SHALL drive extreply=0, set protoerr, and leave the FIFO state unchanged.
REQ-016 SHALL keep outstanding equal to the FIFO occupancy after every clock edge.

Reset
REQ-017 SHALL, on rst, set state=IDLE, empty the FIFO, set outstanding=0, protoerr=0 and starvation counter=0; protoerr is cleared only by rst.
REQ-018 SHALL, on rst taken mid-WLOCK or with replies pending, discard all state; replies arriving after reset fall under REQ-015.
REQ-019 SHALL keep outputs well-defined from the first edge after rst: extreq=0, dcrdy=0 and icrdy=0 until a request is presented.

Configuration
REQ-020 With EXTARB_STARVE_EN defined, SHALL implement REQ-014.
REQ-021 With EXTARB_STARVE_EN undefined, SHALL omit the starvation counter and use fixed dc priority; ic can then starve under continuous dc traffic.

Verification
REQ-022 SHALL verify arbitration: dcreq and icreq both read (sz 15 and 31), extrdy=1 -> dc granted first with extsrc=1, ic granted the next cycle, outstanding=2.
REQ-023 SHALL verify reply routing:
- Stimulus: the replies from REQ-022 as 2 beats then 4 beats.
- Required: extreplyto=1,1,0,0,0,0, and outstanding returns to 0.
REQ-024 SHALL verify the write lock:
- Stimulus: dc write sz=15 accepted; icreq held during the second beat with extrdy=0 for 3 cycles.
- Required: icrdy=0 throughout; state returns to IDLE after the second accept.
REQ-025 SHALL verify the full condition:
- Stimulus: DEPTH=4 reads accepted with no replies, then a fifth read.
- Required: the fifth read gets rdy=0, while a dc write is still granted; one reply pop allows the read the next cycle.
REQ-026 SHALL verify starvation with EXTARB_STARVE_EN:
- Stimulus: continuous dc reads and icreq held.
- Required: ic granted on the 9th cycle when STARVE=8.
- Without EXTARB_STARVE_EN: no ic grant within 50 cycles.
REQ-027 SHALL verify the spurious reply: busreply with the FIFO empty -> protoerr=1 and extreply=0; rst -> protoerr=0.

Source files
------------

// File: rtl/ext_arbiter.sv
// Arbitrates dcache and icache requests onto one external bus and routes read replies back.
// Define EXTARB_STARVE_EN to enable the icache anti-starvation counter (fixed dc priority otherwise).
module ext_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcaddr,
  input  logic [4:0]  dcsz,
  input  logic        dcreq,
  input  logic        dcwr,
  input  logic [63:0] dcwdata,
  output logic        dcrdy,
  input  logic [31:0] icaddr,
  input  logic [4:0]  icsz,
  input  logic        icreq,
  output logic        icrdy,
  output logic [31:0] extaddr,
  output logic [4:0]  extsz,
  output logic        extreq,
  output logic        extwr,
  output logic [63:0] extwdata,
  output logic        extsrc,
  input  logic        extrdy,
  input  logic        busreply,
  input  logic [63:0] busrdata,
  input  logic        buserror,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror,
  output logic [3:0]  outstanding,
  output logic        protoerr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, WLOCK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [DEPTH-1:0] src_q;
  logic [1:0]      blen_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [3:0]      cnt_q;
  logic [1:0]      beat_q;
  logic            protoerr_q;

  logic full_s, empty_s, dc_elig, ic_elig, ic_prio;
  logic dc_win, ic_win, accept, push, rep_valid, pop;

  function automatic logic [1:0] beats_m1(input logic [4:0] sz);
    case (sz)
      5'd15:   return 2'd1;
      5'd31:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign full_s  = (cnt_q == 4'(DEPTH));
  assign empty_s = (cnt_q == 4'd0);
  assign dc_elig = dcreq && (dcwr || !full_s);
  assign ic_elig = icreq && !full_s;

`ifdef EXTARB_STARVE_EN
  localparam int SW = $clog2(STARVE + 1);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (icrdy) begin
      starve_d = '0;
    end else if (icreq && (starve_q != SW'(STARVE))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign ic_prio = (starve_q == SW'(STARVE));
`else
  assign ic_prio = 1'b0;
`endif

  // Winner selection and bus drive; WLOCK pins the bus to the second dc write beat.
  always_comb begin
    state_d  = state_q;
    dc_win   = 1'b0;
    ic_win   = 1'b0;
    extaddr  = 32'd0;
    extsz    = 5'd0;
    extwr    = 1'b0;
    extwdata = 64'd0;
    if (state_q == WLOCK) begin
      dc_win   = dcreq;
      extaddr  = dcaddr;
      extsz    = dcsz;
      extwr    = dcreq;
      extwdata = dcwdata;
      if (dcreq && extrdy) state_d = IDLE;
      else                 state_d = WLOCK;
    end else begin
      if (ic_elig && (!dc_elig || ic_prio)) begin
        ic_win  = 1'b1;
        extaddr = icaddr;
        extsz   = icsz;
      end else if (dc_elig) begin
        dc_win   = 1'b1;
        extaddr  = dcaddr;
        extsz    = dcsz;
        extwr    = dcwr;
        extwdata = dcwdata;
        if (dcwr && extrdy && (dcsz == 5'd15)) state_d = WLOCK;
        else                                   state_d = IDLE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign extreq = dc_win | ic_win;
  assign extsrc = dc_win;
  assign dcrdy  = dc_win & extrdy;
  assign icrdy  = ic_win & extrdy;
  assign accept = extreq & extrdy;
  assign push   = accept & ~extwr;

  assign rep_valid  = busreply & ~empty_s;
  assign pop        = rep_valid & (beat_q == blen_q[rptr_q]);
  assign extreply   = rep_valid;
  assign extreplyto = src_q[rptr_q];
  assign extrdata   = busrdata;
  assign exterror   = buserror;
  assign outstanding = cnt_q;
  assign protoerr    = protoerr_q;

  // State, outstanding-read FIFO and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= 4'd0;
      beat_q     <= 2'd0;
      protoerr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) blen_q[i] <= 2'd0;
    end else begin
      state_q <= state_d;
      if (push) begin
        src_q[wptr_q]  <= extsrc;
        blen_q[wptr_q] <= beats_m1(extsz);
        wptr_q         <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        beat_q <= 2'd0;
      end else if (rep_valid) begin
        beat_q <= beat_q + 2'd1;
      end
      cnt_q <= cnt_q + 4'(push) - 4'(pop);
      if (busreply && empty_s) protoerr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: arbitration vector table plus scoreboarded reply sequences.
module tb_ext_arbiter;
  logic        clk, rst;
  logic [31:0] dcaddr, icaddr, extaddr;
  logic [4:0]  dcsz, icsz, extsz;
  logic        dcreq, dcwr, dcrdy, icreq, icrdy;
  logic [63:0] dcwdata, extwdata, busrdata, extrdata;
  logic        extreq, extwr, extsrc, extrdy, busreply, buserror;
  logic        extreply, extreplyto, exterror, protoerr;
  logic [3:0]  outstanding;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic sb[$];

  ext_arbiter dut (
    .clk(clk), .rst(rst),
    .dcaddr(dcaddr), .dcsz(dcsz), .dcreq(dcreq), .dcwr(dcwr), .dcwdata(dcwdata), .dcrdy(dcrdy),
    .icaddr(icaddr), .icsz(icsz), .icreq(icreq), .icrdy(icrdy),
    .extaddr(extaddr), .extsz(extsz), .extreq(extreq), .extwr(extwr), .extwdata(extwdata),
    .extsrc(extsrc), .extrdy(extrdy),
    .busreply(busreply), .busrdata(busrdata), .buserror(buserror),
    .extreply(extreply), .extreplyto(extreplyto), .extrdata(extrdata), .exterror(exterror),
    .outstanding(outstanding), .protoerr(protoerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dcreq, dcwr, icreq, extrdy;
    logic [4:0] dcsz;
    logic       e_req, e_src, e_dcrdy, e_icrdy, e_wr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int tb_beats(input logic [4:0] sz);
    if (sz == 5'd15) return 2;
    if (sz == 5'd31) return 4;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dcreq = 1'b0; dcwr = 1'b0; dcsz = 5'd0; icreq = 1'b0; icsz = 5'd0;
    extrdy = 1'b0; busreply = 1'b0; buserror = 1'b0; busrdata = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic issue_rd(input logic src, input logic [4:0] sz);
    dcreq = src; icreq = !src; dcwr = 1'b0; dcsz = sz; icsz = sz; extrdy = 1'b1;
    #1;
    chk("issue_src", extsrc, src);
    chk("issue_rdy", src ? dcrdy : icrdy, 1'b1);
    for (int b = 0; b < tb_beats(sz); b++) sb.push_back(src);
    tick();
    dcreq = 1'b0; icreq = 1'b0; extrdy = 1'b0;
  endtask

  task automatic check_route();
    logic e;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL reply_to: reply beat with empty scoreboard");
    end else begin
      e = sb.pop_front();
      chk("reply_to", extreplyto, e);
    end
  endtask

  task automatic reply(input logic [63:0] d);
    busreply = 1'b1; busrdata = d; buserror = d[0];
    #1;
    chk("reply_valid", extreply, 1'b1);
    chk("reply_data", extrdata, d);
    chk("reply_err", exterror, d[0]);
    check_route();
    tick();
    busreply = 1'b0; buserror = 1'b0;
  endtask

  initial begin
    vec_t vt [7];
    int   grant_cyc;
    rst = 1'b1;
    dcaddr = 32'hD000_0040; icaddr = 32'h1C00_0080; dcwdata = 64'h0; idle_inputs();

    // Reset state
    do_reset();
    #1;
    chk("rst_extreq", extreq, 1'b0);
    chk("rst_dcrdy", dcrdy, 1'b0);
    chk("rst_icrdy", icrdy, 1'b0);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_protoerr", protoerr, 1'b0);

    // Arbitration table (no read is accepted, so the FIFO stays empty)
    //          dcreq dcwr icreq rdy  dcsz   req src dcrdy icrdy wr
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      dcreq = vt[i].dcreq; dcwr = vt[i].dcwr; icreq = vt[i].icreq;
      extrdy = vt[i].extrdy; dcsz = vt[i].dcsz; icsz = 5'd0;
      #1;
      chk($sformatf("vec%0d_extreq", i), extreq, vt[i].e_req);
      chk($sformatf("vec%0d_extsrc", i), extsrc, vt[i].e_src);
      chk($sformatf("vec%0d_dcrdy", i), dcrdy, vt[i].e_dcrdy);
      chk($sformatf("vec%0d_icrdy", i), icrdy, vt[i].e_icrdy);
      chk($sformatf("vec%0d_extwr", i), extwr, vt[i].e_wr);
      if (vt[i].e_req)
        chk($sformatf("vec%0d_extaddr", i), extaddr, vt[i].e_src ? dcaddr : icaddr);
      tick();
    end
    idle_inputs();
    #1;
    chk("table_outstanding", outstanding, 4'd0);

    // Both read at once: dc first, ic next cycle
    do_reset();
    dcreq = 1'b1; dcwr = 1'b0; dcsz = 5'd15; icreq = 1'b1; icsz = 5'd31; extrdy = 1'b1;
    #1;
    chk("arb_c1_src", extsrc, 1'b1);
    chk("arb_c1_dcrdy", dcrdy, 1'b1);
    chk("arb_c1_icrdy", icrdy, 1'b0);
    sb.push_back(1'b1); sb.push_back(1'b1);
    tick();
    dcreq = 1'b0;
    #1;
    chk("arb_c2_src", extsrc, 1'b0);
    chk("arb_c2_icrdy", icrdy, 1'b1);
    chk("arb_c2_sz", extsz, 5'd31);
    for (int b = 0; b < 4; b++) sb.push_back(1'b0);
    tick();
    idle_inputs();
    #1;
    chk("arb_outstanding", outstanding, 4'd2);

    // Reply routing: 2 dc beats then 4 ic beats
    for (int b = 0; b < 6; b++) begin
      reply(64'hA5A5_0000_0000_0000 + 64'(b));
      if (b == 1) chk("route_mid_outstanding", outstanding, 4'd1);
    end
    chk("route_outstanding", outstanding, 4'd0);

    // Size codes 7 and 20 are single-beat reads
    issue_rd(1'b1, 5'd7);
    issue_rd(1'b0, 5'd20);
    chk("sz_outstanding2", outstanding, 4'd2);
    reply(64'h11);
    chk("sz_outstanding1", outstanding, 4'd1);
    reply(64'h22);
    chk("sz_outstanding0", outstanding, 4'd0);

    // Write lock
    do_reset();
    dcreq = 1'b1; dcwr = 1'b1; dcsz = 5'd15; dcwdata = 64'hAAAA_0001; extrdy = 1'b1;
    #1;
    chk("wl_first_dcrdy", dcrdy, 1'b1);
    tick();
    dcreq = 1'b0; icreq = 1'b1; extrdy = 1'b0; dcsz = 5'd0;
    #1;
    chk("wl_gap_extreq", extreq, 1'b0);
    chk("wl_gap_icrdy", icrdy, 1'b0);
    tick();
    dcreq = 1'b1; dcwdata = 64'hBBBB_0002;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("wl_stall_icrdy", icrdy, 1'b0);
      chk("wl_stall_src", extsrc, 1'b1);
      chk("wl_stall_wdata", extwdata, 64'hBBBB_0002);
      tick();
    end
    extrdy = 1'b1;
    #1;
    chk("wl_second_dcrdy", dcrdy, 1'b1);
    chk("wl_second_icrdy", icrdy, 1'b0);
    chk("wl_second_wr", extwr, 1'b1);
    tick();
    dcreq = 1'b0; extrdy = 1'b0;
    #1;
    chk("wl_idle_extreq", extreq, 1'b1);
    chk("wl_idle_src", extsrc, 1'b0);
    chk("wl_outstanding", outstanding, 4'd0);

    // Full condition
    do_reset();
    for (int r = 0; r < 4; r++) issue_rd(1'b1, 5'd0);
    chk("full_outstanding", outstanding, 4'd4);
    dcreq = 1'b1; dcwr = 1'b0; extrdy = 1'b1;
    #1;
    chk("full_rd_dcrdy", dcrdy, 1'b0);
    chk("full_rd_extreq", extreq, 1'b0);
    dcwr = 1'b1;
    #1;
    chk("full_wr_dcrdy", dcrdy, 1'b1);
    chk("full_wr_extwr", extwr, 1'b1);
    tick();
    dcwr = 1'b0; busreply = 1'b1;
    #1;
    chk("full_pop_dcrdy", dcrdy, 1'b0);
    check_route();
    tick();
    #1;
    chk("full_after_pop", outstanding, 4'd3);
    chk("full_next_dcrdy", dcrdy, 1'b1);
    check_route();
    sb.push_back(1'b1);
    tick();
    idle_inputs();
    #1;
    chk("full_pushpop_outstanding", outstanding, 4'd3);
    for (int r = 0; r < 3; r++) reply(64'h30 + 64'(r));
    chk("full_drain_outstanding", outstanding, 4'd0);

    // Starvation under continuous dc reads (replies keep the FIFO from filling)
    do_reset();
    dcreq = 1'b1; dcwr = 1'b0; dcsz = 5'd0; icreq = 1'b1; icsz = 5'd0; extrdy = 1'b1;
    grant_cyc = 0;
    for (int k = 1; k <= 50 && grant_cyc == 0; k++) begin
      busreply = (k > 1);
      #1;
      if (icrdy) grant_cyc = k;
      tick();
    end
    idle_inputs();
`ifdef EXTARB_STARVE_EN
    chk("starve_grant_cycle", grant_cyc, 9);
`else
    chk("starve_no_grant", grant_cyc, 0);
`endif

    // Spurious reply, including one whose read was discarded by reset
    do_reset();
    issue_rd(1'b1, 5'd15);
    do_reset();
    #1;
    chk("spur_outstanding_rst", outstanding, 4'd0);
    busreply = 1'b1;
    #1;
    chk("spur_extreply", extreply, 1'b0);
    tick();
    busreply = 1'b0;
    #1;
    chk("spur_protoerr", protoerr, 1'b1);
    chk("spur_outstanding", outstanding, 4'd0);
    tick();
    chk("spur_sticky", protoerr, 1'b1);
    do_reset();
    #1;
    chk("spur_rst_clear", protoerr, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
